uart_tx_scheduler: RTL and testbench

Two-requester byte scheduler in front of the UART transmitter. It arbitrates between a register-file read response (1 byte) and an ALU result (16 bits, sent as 2 bytes) using round-robin, and latches the granted payload. It then issues bytes to UART_TX one at a time through the transmitter's Data_Valid/Busy handshake. It sits in the UART clock domain between the synchronised system-side outputs and UART_TX.

---
 rtl/uart_tx_scheduler.sv | 150 +++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin byte scheduler that feeds UART_TX over its Data_Valid/Busy handshake.
// A register-file read sends one byte; an ALU result sends two bytes, LSB first.
module uart_tx_scheduler #(
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        rd_req_i,
  input  logic [7:0]  rd_data_i,
  input  logic        alu_req_i,
  input  logic [15:0] alu_data_i,
  input  logic        tx_busy_i,
  output logic [7:0]  tx_p_data_o,
  output logic        tx_d_valid_o,
  output logic        rd_ack_o,
  output logic        alu_ack_o,
  output logic        done_o,
  output logic        err_o
);

  // state   | meaning
  // IDLE    | waiting for a request while UART_TX is not busy
  // WAIT_HI | byte issued, waiting for TX_BUSY to rise (timeout armed)
  // WAIT_LO | frame in flight, waiting for TX_BUSY to fall
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO} state_t;

  state_t         state_q, state_d;
  logic [15:0]    hold_q, hold_d;
  logic           two_q, two_d;
  logic           idx_q, idx_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           last_alu_q, last_alu_d;
  logic           d_valid_q, d_valid_d;
  logic           rd_ack_q, rd_ack_d;
  logic           alu_ack_q, alu_ack_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  logic           grant;
  logic           grant_rd;
  logic           timeout;
  logic           more_bytes;
  logic [CW-1:0]  cnt_inc;

  assign grant      = (state_q == IDLE) && !tx_busy_i && (rd_req_i || alu_req_i);
  assign grant_rd   = rd_req_i && (!alu_req_i || last_alu_q);
  assign cnt_inc    = cnt_q + CW'(1);
  assign timeout    = (cnt_inc == CW'(BUSY_TIMEOUT));
  assign more_bytes = two_q && !idx_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      two_q      <= 1'b0;
      idx_q      <= 1'b0;
      cnt_q      <= '0;
      last_alu_q <= 1'b1;
      d_valid_q  <= 1'b0;
      rd_ack_q   <= 1'b0;
      alu_ack_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      two_q      <= two_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      last_alu_q <= last_alu_d;
      d_valid_q  <= d_valid_d;
      rd_ack_q   <= rd_ack_d;
      alu_ack_q  <= alu_ack_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = WAIT_HI;
      WAIT_HI: begin
        if (tx_busy_i)    state_d = WAIT_LO;
        else if (timeout) state_d = IDLE;
      end
      WAIT_LO: begin
        if (!tx_busy_i) state_d = more_bytes ? WAIT_HI : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // hold_q[7:0] is the byte on the wire; hold_q[15:8] is the pending ALU MSB.
  always_comb begin
    hold_d     = hold_q;
    two_d      = two_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    last_alu_d = last_alu_q;
    d_valid_d  = 1'b0;
    rd_ack_d   = 1'b0;
    alu_ack_d  = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant) begin
          hold_d     = grant_rd ? {8'h00, rd_data_i} : alu_data_i;
          two_d      = !grant_rd;
          idx_d      = 1'b0;
          cnt_d      = '0;
          last_alu_d = !grant_rd;
          d_valid_d  = 1'b1;
          rd_ack_d   = grant_rd;
          alu_ack_d  = !grant_rd;
        end
      end
      WAIT_HI: begin
        if (!tx_busy_i) begin
          cnt_d = cnt_inc;
          err_d = timeout;
        end
      end
      WAIT_LO: begin
        if (!tx_busy_i) begin
          if (more_bytes) begin
            hold_d    = {8'h00, hold_q[15:8]};
            idx_d     = 1'b1;
            cnt_d     = '0;
            d_valid_d = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign tx_p_data_o  = hold_q[7:0];
  assign tx_d_valid_o = d_valid_q;
  assign rd_ack_o     = rd_ack_q;
  assign alu_ack_o    = alu_ack_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed/randomised bench for uart_tx_scheduler with a behavioural UART_TX 8N1 busy model.
module tb_uart_tx_scheduler;
  localparam int TO    = 4;
  localparam int FRAME = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_req, alu_req, busy;
  logic [7:0]  rd_data;
  logic [15:0] alu_data;
  logic [7:0]  tx_p_data;
  logic        tx_d_valid, rd_ack, alu_ack, done, err;

  uart_tx_scheduler #(.BUSY_TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .rd_req_i(rd_req), .rd_data_i(rd_data),
    .alu_req_i(alu_req), .alu_data_i(alu_data), .tx_busy_i(busy),
    .tx_p_data_o(tx_p_data), .tx_d_valid_o(tx_d_valid), .rd_ack_o(rd_ack),
    .alu_ack_o(alu_ack), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // UART_TX: samples Data_Valid, raises Busy on that edge and holds it for one frame.
  bit         tie0 = 1'b0, force1 = 1'b0;
  int         bcnt = 0;
  logic [7:0] frames[$];
  initial busy = 1'b0;
  always @(posedge clk) begin
    if (tie0) begin
      busy <= 1'b0;
      bcnt = 0;
    end else if (force1) begin
      busy <= 1'b1;
    end else if (bcnt != 0) begin
      bcnt = bcnt - 1;
      busy <= (bcnt != 0);
    end else if (tx_d_valid) begin
      frames.push_back(tx_p_data);
      bcnt = FRAME;
      busy <= 1'b1;
    end else begin
      busy <= 1'b0;
    end
  end

  // Event monitor: sampled at posedge, so cycle stamps match what a negedge observer sees.
  int   n_dv = 0, n_done = 0, n_err = 0, n_rdack = 0;
  int   fall_c = -100, done_c = 0, last_dv_gap = 0;
  logic busy_prev = 1'b0;
  always @(posedge clk) begin
    if (busy_prev && !busy) fall_c = cyc;
    busy_prev = busy;
    if (tx_d_valid) begin n_dv++; last_dv_gap = cyc - fall_c; end
    if (done) begin n_done++; done_c = cyc; end
    if (err) n_err++;
    if (rd_ack) n_rdack++;
  end

  int n_assert = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns at the negedge where an ACK is visible; kind 0 = RD, 1 = ALU.
  task automatic wait_ack(output int c, output int kind);
    int b = 0;
    kind = -1;
    c = 0;
    while (kind < 0 && b < 80) begin
      @(negedge clk);
      b++;
      if (rd_ack) kind = 0;
      else if (alu_ack) kind = 1;
      c = cyc;
    end
    chk("ack_timeout", (kind >= 0), 1);
  endtask

  task automatic wait_done(input int target);
    int b = 0;
    while (n_done < target && b < 200) begin
      @(negedge clk);
      b++;
    end
    chk("done_timeout", (n_done >= target), 1);
  endtask

  initial begin
    int c, c1, c2, cerr, kind, fb, d0, dn0, e0, a0, got, b, fc;
    logic [7:0]  rdv, exp_b[$];
    logic [15:0] av;

    rst_n = 1'b0; rd_req = 0; alu_req = 0; rd_data = '0; alu_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_pdata", tx_p_data, 8'h00);
    chk("rst_dvalid", tx_d_valid, 0);
    chk("rst_rdack", rd_ack, 0);
    chk("rst_aluack", alu_ack, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single RD byte
    fb = frames.size(); d0 = n_dv; dn0 = n_done;
    rd_data = 8'h93; rd_req = 1'b1; c1 = cyc;
    wait_ack(c, kind);
    chk("rd_kind", kind, 0);
    chk("rd_latency", c - c1, 1);
    chk("rd_dvalid", tx_d_valid, 1);
    chk("rd_pdata", tx_p_data, 8'h93);
    rd_req = 1'b0;
    wait_done(dn0 + 1);
    chk("rd_frames", frames.size() - fb, 1);
    chk("rd_frame0", frames[fb], 8'h93);
    chk("rd_dv_count", n_dv - d0, 1);
    chk("rd_done_lat", done_c - fall_c, 1);

    // single ALU word
    fb = frames.size(); d0 = n_dv; dn0 = n_done;
    alu_data = 16'hA55A; alu_req = 1'b1;
    wait_ack(c, kind);
    chk("alu_kind", kind, 1);
    chk("alu_pdata0", tx_p_data, 8'h5A);
    alu_req = 1'b0;
    wait_done(dn0 + 1);
    repeat (3) @(negedge clk);
    chk("alu_frames", frames.size() - fb, 2);
    chk("alu_lsb", frames[fb], 8'h5A);
    chk("alu_msb", frames[fb+1], 8'hA5);
    chk("alu_dv2_gap", last_dv_gap, 1);
    chk("alu_done_count", n_done - dn0, 1);
    chk("alu_done_lat", done_c - fall_c, 1);
    chk("alu_dv_count", n_dv - d0, 2);

    // simultaneous requests held, fresh random data after each ACK
    fb = frames.size(); dn0 = n_done; exp_b.delete();
    rdv = 8'($urandom); av = 16'($urandom);
    rd_data = rdv; alu_data = av; rd_req = 1'b1; alu_req = 1'b1;
    got = 0; b = 0;
    while (got < 4 && b < 400) begin
      @(negedge clk);
      b++;
      if (rd_ack || alu_ack) begin
        chk("rr_order", alu_ack, got % 2);
        chk("ack_only_idle", n_done - dn0, got);
        if (rd_ack) begin
          exp_b.push_back(rdv);
          rdv = 8'($urandom); rd_data = rdv;
        end else begin
          exp_b.push_back(av[7:0]);
          exp_b.push_back(av[15:8]);
          av = 16'($urandom); alu_data = av;
        end
        got++;
      end
    end
    chk("rr_count", got, 4);
    rd_req = 1'b0; alu_req = 1'b0;
    wait_done(dn0 + 4);
    chk("rr_frames", frames.size() - fb, exp_b.size());
    for (int i = 0; i < exp_b.size(); i++)
      if (fb + i < frames.size()) chk("rr_byte", frames[fb+i], exp_b[i]);

    // Busy never rises: timeout, then re-grant of the held request
    tie0 = 1'b1; dn0 = n_done; e0 = n_err;
    rd_data = 8'($urandom); rd_req = 1'b1;
    wait_ack(c1, kind);
    cerr = -1; c2 = -1; b = 0;
    while (c2 < 0 && b < 40) begin
      @(negedge clk);
      b++;
      if (err && cerr < 0) cerr = cyc;
      if (rd_ack) c2 = cyc;
    end
    chk("err_latency", cerr - c1, TO);
    chk("regrant_latency", c2 - cerr, 1);
    rd_req = 1'b0;
    b = 0;
    while (n_err < e0 + 2 && b < 40) begin @(negedge clk); b++; end
    chk("err_count", n_err - e0, 2);
    chk("err_no_done", n_done - dn0, 0);
    tie0 = 1'b0;
    repeat (2) @(negedge clk);

    // reset during the second ALU frame
    d0 = n_dv;
    alu_data = 16'($urandom); alu_req = 1'b1;
    wait_ack(c, kind);
    alu_req = 1'b0;
    b = 0;
    while (n_dv < d0 + 2 && b < 60) begin @(negedge clk); b++; end
    repeat (3) @(negedge clk);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_pdata", tx_p_data, 8'h00);
    chk("mrst_dvalid", tx_d_valid, 0);
    chk("mrst_acks", {rd_ack, alu_ack}, 2'b00);
    chk("mrst_done_err", {done, err}, 2'b00);
    dn0 = n_done; e0 = n_err;
    rst_n = 1'b1;
    rd_data = 8'($urandom); alu_data = 16'($urandom);
    rd_req = 1'b1; alu_req = 1'b1;
    wait_ack(c, kind);
    chk("post_rst_tie", kind, 0);
    chk("post_rst_quiet", (n_done - dn0) + (n_err - e0), 0);
    rd_req = 1'b0; alu_req = 1'b0;
    wait_done(dn0 + 1);

    // external activity holds Busy high in IDLE
    force1 = 1'b1;
    repeat (2) @(negedge clk);
    a0 = n_rdack; d0 = n_dv;
    rd_data = 8'($urandom); rd_req = 1'b1;
    repeat (6) @(negedge clk);
    chk("busy_hold_ack", n_rdack - a0, 0);
    chk("busy_hold_dv", n_dv - d0, 0);
    force1 = 1'b0;
    fc = -1; c = -1; b = 0;
    while (c < 0 && b < 20) begin
      @(negedge clk);
      b++;
      if (!busy && fc < 0) fc = cyc;
      if (rd_ack) c = cyc;
    end
    chk("busy_release_lat", c - fc, 1);
    rd_req = 1'b0;
    wait_done(n_done + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
